// File: rtl/shell_region.sv
// shell_region: AXI4-Lite CSR slave plus an AXI4 burst slave over on-chip memory (DMA path).
// Latency: CSR write response 1 cycle after both AW and W are held; CSR read data and each DMA read beat are registered (1 cycle).
// Backpressure: CSR channels stall while a response is pending; DMA write/read FSMs accept one burst at a time each and hold outputs until ready.
//
// Ports:
//   FPGA_SYSCLK, RESET          - sole clock (rising edge), synchronous active-high reset
//   s_axil_aw*/w*/b*/ar*/r*     - AXI4-Lite CSR slave (ID, CTRL, STATUS, SCRATCH, WR_BEATS, RD_BEATS)
//   s_axi_aw*/w*/b*/ar*/r*      - AXI4 burst slave backed by MEM_DEPTH x AXI_DATA_W memory
module shell_region #(
  parameter int          AXIL_ADDR_W = 12,
  parameter int          AXI_ADDR_W  = 32,
  parameter int          AXI_DATA_W  = 64,
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] ID_VALUE    = 32'h5648_4442
) (
  input  logic                      FPGA_SYSCLK,
  input  logic                      RESET,
  // CSR slave
  input  logic [AXIL_ADDR_W-1:0]    s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]    s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  // DMA slave
  input  logic [AXI_ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_W-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  // ---------------------------------------------------------------- state
  logic                   r_aw_held;
  logic [7:0]             r_aw_addr;
  logic                   r_w_held;
  logic [31:0]            r_w_data;
  logic [3:0]             r_w_strb;
  logic                   r_axil_bvalid;
  logic [1:0]             r_axil_bresp;
  logic                   r_axil_rvalid;
  logic [31:0]            r_axil_rdata;
  logic [1:0]             r_axil_rresp;

  logic                   r_dma_en;
  logic [31:0]            r_scratch;
  logic [31:0]            r_wr_beats;
  logic [31:0]            r_rd_beats;

  logic [1:0]             r_wr_state;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [7:0]             r_wr_len;
  logic [7:0]             r_wr_cnt;
  logic                   r_wr_fixed;
  logic                   r_wr_err;

  logic [0:0]             r_rd_state;
  logic [IDX_W-1:0]       r_rd_idx;
  logic [7:0]             r_rd_len;
  logic [7:0]             r_rd_cnt;
  logic                   r_rd_fixed;
  logic                   r_rd_err;
  logic                   r_rvalid;
  logic                   r_rlast;
  logic [AXI_DATA_W-1:0]  r_rdata;

  logic [AXI_DATA_W-1:0]  r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------- CSR handshakes
  logic        w_axil_aw_hs;
  logic        w_axil_w_hs;
  logic        w_axil_ar_hs;
  logic        w_csr_wr;
  logic        w_csr_wr_mapped;
  logic        w_cnt_clr;
  logic        w_wr_busy;
  logic        w_rd_busy;
  logic [31:0] w_csr_rdata;
  logic        w_csr_rok;

  assign s_axil_awready = !r_aw_held && !r_axil_bvalid;
  assign s_axil_wready  = !r_w_held  && !r_axil_bvalid;
  assign s_axil_arready = !r_axil_rvalid;
  assign s_axil_bvalid  = r_axil_bvalid;
  assign s_axil_bresp   = r_axil_bresp;
  assign s_axil_rvalid  = r_axil_rvalid;
  assign s_axil_rdata   = r_axil_rdata;
  assign s_axil_rresp   = r_axil_rresp;

  assign w_axil_aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_axil_w_hs  = s_axil_wvalid  && s_axil_wready;
  assign w_axil_ar_hs = s_axil_arvalid && s_axil_arready;
  assign w_csr_wr     = r_aw_held && r_w_held;

  assign w_wr_busy = (r_wr_state != WR_IDLE);
  assign w_rd_busy = (r_rd_state != RD_IDLE);

  always_comb begin
    w_csr_wr_mapped = 1'b0;
    case (r_aw_addr)
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14: w_csr_wr_mapped = 1'b1;
      default:                                  w_csr_wr_mapped = 1'b0;
    endcase
  end

  // cnt_clr is a pulse: it only exists as the side effect of this write
  assign w_cnt_clr = w_csr_wr && (r_aw_addr == 8'h04) && r_w_strb[0] && r_w_data[1];

  always_comb begin
    w_csr_rdata = 32'd0;
    w_csr_rok   = 1'b1;
    case (s_axil_araddr[7:0])
      8'h00:   w_csr_rdata = ID_VALUE;
      8'h04:   w_csr_rdata = {31'd0, r_dma_en};
      8'h08:   w_csr_rdata = {30'd0, w_rd_busy, w_wr_busy};
      8'h0C:   w_csr_rdata = r_scratch;
      8'h10:   w_csr_rdata = r_wr_beats;
      8'h14:   w_csr_rdata = r_rd_beats;
      default: w_csr_rok   = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- CSR write path
  // AW/W can only be captured while bvalid=0, so a commit never overlaps a B handshake.
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) begin
      r_aw_held     <= 1'b0;
      r_aw_addr     <= 8'd0;
      r_w_held      <= 1'b0;
      r_w_data      <= 32'd0;
      r_w_strb      <= 4'd0;
      r_axil_bvalid <= 1'b0;
      r_axil_bresp  <= RESP_OKAY;
      r_dma_en      <= 1'b0;
      r_scratch     <= 32'd0;
    end else begin
      if (w_axil_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axil_awaddr[7:0];
      end
      if (w_axil_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axil_wdata;
        r_w_strb <= s_axil_wstrb;
      end
      if (w_csr_wr) begin
        r_aw_held     <= 1'b0;
        r_w_held      <= 1'b0;
        r_axil_bvalid <= 1'b1;
        r_axil_bresp  <= w_csr_wr_mapped ? RESP_OKAY : RESP_SLVERR;
        case (r_aw_addr)
          8'h04: if (r_w_strb[0]) r_dma_en <= r_w_data[0];
          8'h0C: begin
            for (int b = 0; b < 4; b++) begin
              if (r_w_strb[b]) r_scratch[8*b +: 8] <= r_w_data[8*b +: 8];
            end
          end
          default: ;
        endcase
      end else if (r_axil_bvalid && s_axil_bready) begin
        r_axil_bvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- CSR read path
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) begin
      r_axil_rvalid <= 1'b0;
      r_axil_rdata  <= 32'd0;
      r_axil_rresp  <= RESP_OKAY;
    end else if (w_axil_ar_hs) begin
      r_axil_rvalid <= 1'b1;
      r_axil_rdata  <= w_csr_rdata;
      r_axil_rresp  <= w_csr_rok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_axil_rvalid && s_axil_rready) begin
      r_axil_rvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- DMA write FSM
  logic             w_aw_hs;
  logic             w_wr_beat;
  logic [IDX_W-1:0] w_aw_idx;

  assign s_axi_awready = (r_wr_state == WR_IDLE);
  assign s_axi_wready  = (r_wr_state == WR_DATA);
  assign s_axi_bvalid  = (r_wr_state == WR_RESP);
  assign s_axi_bresp   = (s_axi_bvalid && r_wr_err) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_wr_beat = s_axi_wvalid && s_axi_wready;
  assign w_aw_idx  = s_axi_awaddr[OFF_W +: IDX_W];

  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) begin
      r_wr_state <= WR_IDLE;
      r_wr_idx   <= '0;
      r_wr_len   <= 8'd0;
      r_wr_cnt   <= 8'd0;
      r_wr_fixed <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_wr_idx   <= w_aw_idx;
            r_wr_len   <= s_axi_awlen;
            r_wr_cnt   <= 8'd0;
            r_wr_fixed <= (s_axi_awburst == BURST_FIXED);
            r_wr_err   <= !r_dma_en;
            r_wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_wr_beat) begin
            if (!r_wr_fixed) r_wr_idx <= r_wr_idx + IDX_W'(1);
            // an early wlast ends the burst as well as reaching awlen
            if (s_axi_wlast || (r_wr_cnt == r_wr_len)) r_wr_state <= WR_RESP;
            else                                       r_wr_cnt   <= r_wr_cnt + 8'd1;
          end
        end
        WR_RESP: if (s_axi_bready) r_wr_state <= WR_IDLE;
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Memory is never cleared; writes are suppressed during reset and for rejected bursts.
  always_ff @(posedge FPGA_SYSCLK) begin
    if (!RESET && w_wr_beat && !r_wr_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- DMA read FSM
  logic             w_ar_hs;
  logic             w_rd_beat;
  logic [IDX_W-1:0] w_ar_idx;
  logic [IDX_W-1:0] w_rd_next_idx;

  assign s_axi_arready = (r_rd_state == RD_IDLE);
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = (r_rvalid && r_rd_err) ? RESP_SLVERR : RESP_OKAY;

  assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
  assign w_rd_beat     = r_rvalid && s_axi_rready;
  assign w_ar_idx      = s_axi_araddr[OFF_W +: IDX_W];
  assign w_rd_next_idx = r_rd_fixed ? r_rd_idx : r_rd_idx + IDX_W'(1);

  // The next beat is fetched on the handshake itself, so beats can stream back-to-back.
  // A same-cycle write to that word is not visible (old data is returned).
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET) begin
      r_rd_state <= RD_IDLE;
      r_rd_idx   <= '0;
      r_rd_len   <= 8'd0;
      r_rd_cnt   <= 8'd0;
      r_rd_fixed <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rd_idx   <= w_ar_idx;
            r_rd_len   <= s_axi_arlen;
            r_rd_cnt   <= 8'd0;
            r_rd_fixed <= (s_axi_arburst == BURST_FIXED);
            r_rd_err   <= !r_dma_en;
            r_rvalid   <= 1'b1;
            r_rlast    <= (s_axi_arlen == 8'd0);
            r_rdata    <= r_dma_en ? r_mem[w_ar_idx] : '0;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_rd_beat) begin
            if (r_rd_cnt == r_rd_len) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_rd_state <= RD_IDLE;
            end else begin
              r_rd_idx <= w_rd_next_idx;
              r_rd_cnt <= r_rd_cnt + 8'd1;
              r_rlast  <= ((r_rd_cnt + 8'd1) == r_rd_len);
              r_rdata  <= r_rd_err ? '0 : r_mem[w_rd_next_idx];
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- beat counters
  always_ff @(posedge FPGA_SYSCLK) begin
    if (RESET || w_cnt_clr) begin
      r_wr_beats <= 32'd0;
      r_rd_beats <= 32'd0;
    end else begin
      if (w_wr_beat && !r_wr_err) r_wr_beats <= r_wr_beats + 32'd1;
      if (w_rd_beat && !r_rd_err) r_rd_beats <= r_rd_beats + 32'd1;
    end
  end

  // Address bits outside the decoded register/word fields are ignored by design.
  logic w_unused;
  assign w_unused = &{1'b0,
                      s_axil_awaddr[AXIL_ADDR_W-1:8], s_axil_araddr[AXIL_ADDR_W-1:8],
                      s_axi_awaddr[OFF_W-1:0], s_axi_awaddr[AXI_ADDR_W-1:OFF_W+IDX_W],
                      s_axi_araddr[OFF_W-1:0], s_axi_araddr[AXI_ADDR_W-1:OFF_W+IDX_W]};

endmodule

// File: tb/tb_shell_region.sv
// Bench for shell_region: CSR and DMA transactions with a scoreboard queue of
// expected responses and a byte-level memory model for DMA data.
module tb_shell_region;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [11:0] axil_awaddr;  logic axil_awvalid;  logic axil_awready;
  logic [31:0] axil_wdata;   logic [3:0] axil_wstrb; logic axil_wvalid; logic axil_wready;
  logic [1:0]  axil_bresp;   logic axil_bvalid;   logic axil_bready;
  logic [11:0] axil_araddr;  logic axil_arvalid;  logic axil_arready;
  logic [31:0] axil_rdata;   logic [1:0] axil_rresp; logic axil_rvalid; logic axil_rready;

  logic [31:0] axi_awaddr;   logic [7:0] axi_awlen; logic [1:0] axi_awburst;
  logic        axi_awvalid;  logic axi_awready;
  logic [63:0] axi_wdata;    logic [7:0] axi_wstrb; logic axi_wlast; logic axi_wvalid; logic axi_wready;
  logic [1:0]  axi_bresp;    logic axi_bvalid;    logic axi_bready;
  logic [31:0] axi_araddr;   logic [7:0] axi_arlen; logic [1:0] axi_arburst;
  logic        axi_arvalid;  logic axi_arready;
  logic [63:0] axi_rdata;    logic [1:0] axi_rresp; logic axi_rlast; logic axi_rvalid; logic axi_rready;

  shell_region dut (
    .FPGA_SYSCLK(clk), .RESET(rst),
    .s_axil_awaddr(axil_awaddr), .s_axil_awvalid(axil_awvalid), .s_axil_awready(axil_awready),
    .s_axil_wdata(axil_wdata), .s_axil_wstrb(axil_wstrb), .s_axil_wvalid(axil_wvalid),
    .s_axil_wready(axil_wready),
    .s_axil_bresp(axil_bresp), .s_axil_bvalid(axil_bvalid), .s_axil_bready(axil_bready),
    .s_axil_araddr(axil_araddr), .s_axil_arvalid(axil_arvalid), .s_axil_arready(axil_arready),
    .s_axil_rdata(axil_rdata), .s_axil_rresp(axil_rresp), .s_axil_rvalid(axil_rvalid),
    .s_axil_rready(axil_rready),
    .s_axi_awaddr(axi_awaddr), .s_axi_awlen(axi_awlen), .s_axi_awburst(axi_awburst),
    .s_axi_awvalid(axi_awvalid), .s_axi_awready(axi_awready),
    .s_axi_wdata(axi_wdata), .s_axi_wstrb(axi_wstrb), .s_axi_wlast(axi_wlast),
    .s_axi_wvalid(axi_wvalid), .s_axi_wready(axi_wready),
    .s_axi_bresp(axi_bresp), .s_axi_bvalid(axi_bvalid), .s_axi_bready(axi_bready),
    .s_axi_araddr(axi_araddr), .s_axi_arlen(axi_arlen), .s_axi_arburst(axi_arburst),
    .s_axi_arvalid(axi_arvalid), .s_axi_arready(axi_arready),
    .s_axi_rdata(axi_rdata), .s_axi_rresp(axi_rresp), .s_axi_rlast(axi_rlast),
    .s_axi_rvalid(axi_rvalid), .s_axi_rready(axi_rready)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, INCR = 2'b01, FIXED = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  string       sb_tag[$];
  logic [63:0] sb_exp[$];

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    if (sb_exp.size() == 0) chk("sb_underflow", 64'(sb_exp.size()), 64'd1);
    else chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
  endtask

  // ---------------------------------------------------------------- memory model
  logic [63:0] model [256];
  logic [63:0] wd [8];
  logic [7:0]  ws [8];

  // ---------------------------------------------------------------- handshake waits
  logic [63:0] cap_dat;
  logic [1:0]  cap_resp;

  function automatic bit hs(input int ch);
    case (ch)
      1: return axil_arvalid && axil_arready;
      2: return axil_bvalid  && axil_bready;
      3: return axil_rvalid  && axil_rready;
      4: return axi_awvalid  && axi_awready;
      5: return axi_wvalid   && axi_wready;
      6: return axi_bvalid   && axi_bready;
      7: return axi_arvalid  && axi_arready;
      default: return 1'b0;
    endcase
  endfunction

  // Returns #1 after the edge that completed the handshake; outputs captured at the negedge before it.
  task automatic wait_hs(input int ch, input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs(ch)) begin
        got      = 1'b1;
        cap_dat  = (ch == 3) ? 64'(axil_rdata) : 64'd0;
        cap_resp = (ch == 2) ? axil_bresp : (ch == 3) ? axil_rresp : axi_bresp;
      end
      @(posedge clk); #1;
      if (got) break;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 64'(got), 64'd1);
      sb_tag.delete();
      sb_exp.delete();
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input string tag);
    bit aw_done, w_done, a_hs, w_hs, got;
    sb_push({tag, "_bresp"}, 64'(exp_resp));
    axil_awaddr = a; axil_awvalid = 1'b1;
    axil_wdata = d; axil_wstrb = s; axil_wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a_hs = axil_awvalid && axil_awready;
      w_hs = axil_wvalid && axil_wready;
      @(posedge clk); #1;
      if (a_hs) begin axil_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin axil_wvalid = 1'b0;  w_done  = 1'b1; end
      if (aw_done && w_done) break;
    end
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      chk({tag, "_aw_w_timeout"}, 64'(aw_done && w_done), 64'd1);
      sb_tag.delete(); sb_exp.delete();
    end else begin
      wait_hs(2, tag, got);
      if (got) sb_pop(64'(cap_resp));
    end
  endtask

  task automatic axil_read(input logic [11:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp, input string tag);
    bit got;
    sb_push({tag, "_rdata"}, 64'(exp_d));
    sb_push({tag, "_rresp"}, 64'(exp_resp));
    axil_araddr = a; axil_arvalid = 1'b1;
    wait_hs(1, tag, got);
    axil_arvalid = 1'b0;
    if (got) begin
      wait_hs(3, tag, got);
      if (got) begin
        sb_pop(cap_dat);
        sb_pop(64'(cap_resp));
      end
    end
  endtask

  // Drives nbeats beats from wd/ws (wlast on the last one). stop_after>=0 abandons
  // the burst after that many beats without collecting a response.
  task automatic dma_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input bit exp_err, input int nbeats, input int stop_after,
                           input string tag);
    bit got;
    logic [7:0] idx;
    idx = a[10:3];
    axi_awaddr = a; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
    wait_hs(4, {tag, "_aw"}, got);
    axi_awvalid = 1'b0;
    if (!got) return;
    for (int b = 0; b < nbeats; b++) begin
      if (b == stop_after) return;
      axi_wdata = wd[b]; axi_wstrb = ws[b]; axi_wlast = (b == nbeats - 1); axi_wvalid = 1'b1;
      wait_hs(5, {tag, "_w"}, got);
      axi_wvalid = 1'b0; axi_wlast = 1'b0;
      if (!got) return;
      if (!exp_err)
        for (int k = 0; k < 8; k++)
          if (ws[b][k]) model[idx][8*k +: 8] = wd[b][8*k +: 8];
      if (burst != FIXED) idx = idx + 8'd1;
    end
    sb_push({tag, "_bresp"}, 64'(exp_err ? SLVERR : OKAY));
    wait_hs(6, {tag, "_b"}, got);
    if (got) sb_pop(64'(cap_resp));
  endtask

  task automatic dma_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input bit exp_err, input string tag);
    bit got;
    logic [7:0] idx;
    idx = a[10:3];
    for (int b = 0; b <= int'(len); b++) begin
      sb_push($sformatf("%s_d%0d", tag, b), exp_err ? 64'd0 : model[idx]);
      sb_push($sformatf("%s_last%0d", tag, b), 64'(b == int'(len)));
      sb_push($sformatf("%s_resp%0d", tag, b), 64'(exp_err ? SLVERR : OKAY));
      if (burst != FIXED) idx = idx + 8'd1;
    end
    axi_araddr = a; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1;
    wait_hs(7, {tag, "_ar"}, got);
    axi_arvalid = 1'b0;
    if (!got) return;
    for (int b = 0; b <= int'(len); b++) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        axi_rready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (axi_rvalid && axi_rready) begin
          got = 1'b1;
          sb_pop(axi_rdata);
          sb_pop(64'(axi_rlast));
          sb_pop(64'(axi_rresp));
        end
        @(posedge clk); #1;
        if (got) break;
      end
      if (!got) begin
        chk($sformatf("%s_beat%0d_timeout", tag, b), 64'(got), 64'd1);
        sb_tag.delete(); sb_exp.delete();
        break;
      end
    end
    axi_rready = 1'b1;
  endtask

  function automatic void fill(input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3);
    wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
    for (int i = 0; i < 8; i++) ws[i] = 8'hFF;
  endfunction

  // ---------------------------------------------------------------- main sequence
  initial begin
    rst = 1'b1;
    axil_awaddr = '0; axil_awvalid = 1'b0; axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0;
    axil_bready = 1'b1; axil_araddr = '0; axil_arvalid = 1'b0; axil_rready = 1'b1;
    axi_awaddr = '0; axi_awlen = '0; axi_awburst = INCR; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
    axi_araddr = '0; axi_arlen = '0; axi_arburst = INCR; axi_arvalid = 1'b0; axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_axil_awready", 64'(axil_awready), 64'd1);
    chk("rst_axil_bvalid",  64'(axil_bvalid),  64'd0);
    chk("rst_axil_rvalid",  64'(axil_rvalid),  64'd0);
    chk("rst_axi_awready",  64'(axi_awready),  64'd1);
    chk("rst_axi_wready",   64'(axi_wready),   64'd0);
    chk("rst_axi_bvalid",   64'(axi_bvalid),   64'd0);
    chk("rst_axi_rvalid",   64'(axi_rvalid),   64'd0);
    chk("rst_axi_rlast",    64'(axi_rlast),    64'd0);
    chk("rst_axi_rdata",    axi_rdata,         64'd0);
    axil_read(12'h000, 32'h5648_4442, OKAY, "id");
    axil_read(12'h00C, 32'h0, OKAY, "scratch_rst");
    axil_read(12'h004, 32'h0, OKAY, "ctrl_rst");
    axil_read(12'h008, 32'h0, OKAY, "status_rst");

    // CSR strobes, RO write, unmapped
    axil_write(12'h00C, 32'hDEAD_BEEF, 4'b0011, OKAY, "scratch_wr");
    axil_read(12'h00C, 32'h0000_BEEF, OKAY, "scratch_strb");
    axil_write(12'h000, 32'h1234_5678, 4'hF, OKAY, "id_wr");
    axil_read(12'h000, 32'h5648_4442, OKAY, "id_ro");
    axil_write(12'h040, 32'h1, 4'hF, SLVERR, "unmapped_wr");
    axil_read(12'h040, 32'h0, SLVERR, "unmapped_rd");
    axil_read(12'hF04, 32'h0, OKAY, "ctrl_alias");

    // DMA disabled: rejected bursts, no counting
    fill(64'h11, 64'h22, 64'h33, 64'h44);
    dma_write(32'h100, 8'd3, INCR, 1'b1, 4, -1, "dw_dis");
    axil_read(12'h010, 32'd0, OKAY, "wrbeats_dis");
    dma_read(32'h100, 8'd3, INCR, 1'b1, "dr_dis");
    axil_read(12'h014, 32'd0, OKAY, "rdbeats_dis");

    // DMA enabled INCR burst
    axil_write(12'h004, 32'h1, 4'hF, OKAY, "ctrl_en");
    fill(64'd1, 64'd2, 64'd3, 64'd4);
    dma_write(32'h100, 8'd3, INCR, 1'b0, 4, -1, "dw_incr");
    dma_read(32'h100, 8'd3, INCR, 1'b0, "dr_incr");
    axil_read(12'h010, 32'd4, OKAY, "wrbeats_4");
    axil_read(12'h014, 32'd4, OKAY, "rdbeats_4");
    axil_write(12'h004, 32'h3, 4'hF, OKAY, "ctrl_clr");
    axil_read(12'h004, 32'h1, OKAY, "ctrl_clr_rd");
    axil_read(12'h010, 32'd0, OKAY, "wrbeats_clr");
    axil_read(12'h014, 32'd0, OKAY, "rdbeats_clr");

    // rejected burst leaves memory untouched
    axil_write(12'h004, 32'h0, 4'hF, OKAY, "ctrl_dis");
    fill(64'h99, 64'h98, 64'h97, 64'h96);
    dma_write(32'h100, 8'd3, INCR, 1'b1, 4, -1, "dw_dis2");
    axil_write(12'h004, 32'h1, 4'hF, OKAY, "ctrl_en2");
    dma_read(32'h100, 8'd3, INCR, 1'b0, "dr_unchanged");
    axil_read(12'h010, 32'd0, OKAY, "wrbeats_dis2");

    // partial strobe
    fill(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0);
    dma_write(32'h300, 8'd0, INCR, 1'b0, 1, -1, "dw_ones");
    wd[0] = 64'd0; ws[0] = 8'h0F;
    dma_write(32'h300, 8'd0, INCR, 1'b0, 1, -1, "dw_part");
    dma_read(32'h300, 8'd0, INCR, 1'b0, "dr_part");

    // index wrap at word 255
    fill(64'hAAAA_0001, 64'hBBBB_0002, 64'd0, 64'd0);
    dma_write(32'h7F8, 8'd1, INCR, 1'b0, 2, -1, "dw_wrap");
    dma_read(32'h000, 8'd0, INCR, 1'b0, "dr_word0");
    dma_read(32'h7F8, 8'd1, INCR, 1'b0, "dr_wrap");

    // FIXED burst keeps one word
    fill(64'h5005, 64'h6006, 64'h7007, 64'd0);
    dma_write(32'h050, 8'd2, FIXED, 1'b0, 3, -1, "dw_fixed");
    dma_read(32'h050, 8'd0, INCR, 1'b0, "dr_fixed");
    dma_read(32'h050, 8'd1, FIXED, 1'b0, "dr_fixed2");

    // early wlast ends the burst after 2 beats
    axil_write(12'h004, 32'h3, 4'hF, OKAY, "ctrl_clr2");
    fill(64'hE1, 64'hE2, 64'hE3, 64'hE4);
    dma_write(32'h600, 8'd3, INCR, 1'b0, 2, -1, "dw_early");
    axil_read(12'h010, 32'd2, OKAY, "wrbeats_early");
    axil_read(12'h008, 32'd0, OKAY, "status_idle");

    // reset in the middle of a burst
    fill(64'hC1, 64'hC2, 64'hC3, 64'hC4);
    dma_write(32'h400, 8'd3, INCR, 1'b0, 4, 2, "dw_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_wready",  64'(axi_wready),  64'd0);
    chk("mid_rst_bvalid",  64'(axi_bvalid),  64'd0);
    chk("mid_rst_awready", 64'(axi_awready), 64'd1);
    chk("mid_rst_rvalid",  64'(axi_rvalid),  64'd0);
    axil_read(12'h008, 32'd0, OKAY, "status_mid_rst");
    axil_read(12'h004, 32'd0, OKAY, "ctrl_mid_rst");
    axil_write(12'h004, 32'h1, 4'hF, OKAY, "ctrl_en3");
    dma_read(32'h400, 8'd1, INCR, 1'b0, "dr_retained");
    fill(64'hD1, 64'hD2, 64'hD3, 64'hD4);
    dma_write(32'h400, 8'd3, INCR, 1'b0, 4, -1, "dw_after_rst");
    dma_read(32'h400, 8'd3, INCR, 1'b0, "dr_after_rst");
    axil_read(12'h010, 32'd4, OKAY, "wrbeats_after_rst");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shell_region.md
Name: shell_region

Overview:
- Single-clock shell region. Combines an AXI4-Lite CSR slave (control/status registers) and an AXI4 burst slave backed by on-chip memory (DMA data path).
- Sits between the host bridge (PCIe/DMA side) and user logic.
- Host software first initializes the CSRs over AXI4-Lite, then moves DMA bursts over AXI4.

Parameters:
- AXIL_ADDR_W, 12, CSR address width (byte address).
- AXI_ADDR_W, 32, DMA address width (byte address).
- AXI_DATA_W, 64, DMA data width; power of 2, 32..256.
- MEM_DEPTH, 256, DMA memory depth in AXI_DATA_W words; power of 2.
- ID_VALUE, 32'h5648_4442, constant returned by the ID register.

Ports:
- FPGA_SYSCLK  in  1  sole clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- s_axil_awaddr/awvalid/awready  in/in/out  AXIL_ADDR_W/1/1  CSR write-address channel.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  CSR write-data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  CSR write-response channel.
- s_axil_araddr/arvalid/arready  in/in/out  AXIL_ADDR_W/1/1  CSR read-address channel.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  CSR read-data channel.
- s_axi_awaddr/awlen/awburst/awvalid/awready  in/in/in/in/out  AXI_ADDR_W/8/2/1/1  DMA write-address channel.
- s_axi_wdata/wstrb/wlast/wvalid/wready  in/in/in/in/out  AXI_DATA_W/AXI_DATA_W/8/1/1/1  DMA write-data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  DMA write-response channel.
- s_axi_araddr/arlen/arburst/arvalid/arready  in/in/in/in/out  AXI_ADDR_W/8/2/1/1  DMA read-address channel.
- s_axi_rdata/rresp/rlast/rvalid/rready  out/out/out/out/in  AXI_DATA_W/2/1/1/1  DMA read-data channel.

Behaviour:
- Reset: all valid outputs 0; bresp/rresp/rdata/rlast 0; CTRL=0; SCRATCH=0; counters=0; both DMA FSMs IDLE. Memory contents are not cleared, including on reset mid-operation.
- CSR write path:
  - AW and W are captured independently. awready=1 while no AW is held and bvalid=0; wready follows the same rule for W.
  - When both are held, the register updates (honoring wstrb) and bvalid rises the next cycle, held until bready.
- CSR read path: arready=1 while rvalid=0. rvalid/rdata are registered one cycle after the AR handshake and held until rready.
- CSR map (addr[7:0]; upper address bits ignored):
  - 0x00 ID: RO, ID_VALUE.
  - 0x04 CTRL: bit0 dma_en RW; bit1 cnt_clr, write 1 clears both counters, always reads 0; other bits read 0.
  - 0x08 STATUS: RO; bit0 = write FSM not IDLE, bit1 = read FSM not IDLE.
  - 0x0C SCRATCH: RW, 32 bits.
  - 0x10 WR_BEATS: RO; accepted DMA write beats; 32-bit, wraps.
  - 0x14 RD_BEATS: RO; completed DMA read beats; 32-bit, wraps.
  - Unmapped addresses: writes ignored with SLVERR (2'b10); reads return 0 with SLVERR. Mapped accesses return OKAY.
  - A counter clear in the same cycle as a count increment: the clear wins.
- DMA word index: idx = (addr >> log2(AXI_DATA_W/8)) mod MEM_DEPTH. The index wraps at MEM_DEPTH.
- DMA write FSM (IDLE -> DATA -> RESP):
  - IDLE: awready=1; on handshake latch idx, len, burst and err = !dma_en.
  - DATA: wready=1. Each beat writes mem[idx] byte-wise per wstrb, but only when err=0. Counter increments only when err=0.
  - After each beat, idx+1 for INCR/WRAP (WRAP is treated as INCR); idx is unchanged for FIXED.
  - The beat with wlast, or beat number len (whichever comes first), moves the FSM to RESP.
  - RESP: bvalid=1, bresp = err ? SLVERR : OKAY; returns to IDLE on bready.
- DMA read FSM (IDLE -> DATA):
  - IDLE: arready=1; latch parameters the same way as the write FSM.
  - Next cycle: rvalid=1 with registered rdata = mem[idx], or 0 if err; rresp = err ? SLVERR : OKAY; rlast=1 on beat len.
  - On each rvalid&rready, advance idx and present the next beat the following cycle. Back-to-back beats are allowed.
  - After the last beat handshake, return to IDLE.
- Read and write FSMs run concurrently. A read of a word in the same cycle that word is written returns the old data.
- dma_en changes affect only bursts accepted after the change.

Test Plan:
- Reset, then CSR read 0x00 -> rdata=0x56484442, rresp=OKAY; read 0x0C -> 0.
- Write SCRATCH 0x0C=0xDEADBEEF with wstrb=4'b0011, after SCRATCH=0 -> reads 0x0000BEEF. Write 0x40 -> bresp=SLVERR; read 0x40 -> rdata=0, rresp=SLVERR.
- dma_en=0: DMA write awaddr=0x100, awlen=3 -> bresp=SLVERR, memory unchanged, WR_BEATS=0.
- CTRL=1; INCR write awaddr=0x100, awlen=3, data 1,2,3,4 -> bresp=OKAY. Read back same range -> 1,2,3,4 with rlast on 4th beat. WR_BEATS=4, RD_BEATS=4. Write CTRL=3 -> both counters read 0.
- Partial strobe: wstrb=0x0F on word holding 0xFFFFFFFF_FFFFFFFF with wdata=0 -> reads 0xFFFFFFFF_00000000. INCR write at word 255, awlen=1 -> second beat lands at word 0.
- Assert RESET mid-burst (after 2 of 4 beats) -> valids drop, STATUS=0 next cycle, the 2 written words are retained. A new burst then completes normally.
